gate_selftest_ctrl: RTL

Sequencer that exercises the two-input `logic_gates` datapath and checks its seven outputs. On a start request it drives `a`/`b` through all four input vectors and waits a programmable settle time per vector. It samples the gate outputs, compares them against a built-in truth table, and reports a per-vector fail mask, a per-gate error mask and an overall pass flag. It sits between a control/status register interface and one `logic_gates` instance, as a power-on or on-demand self-test.

---
 rtl/gate_selftest_ctrl.sv | 77 +++++++
 1 files changed

// File: rtl/gate_selftest_ctrl.sv
// gate_selftest_ctrl: walks logic_gates through all input vectors and checks its outputs against a truth table
module gate_selftest_ctrl #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] gate_res,
  output logic       gate_a,
  output logic       gate_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [6:0] err_bits
);
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
  state_t state, state_nx;
  logic [1:0] vec;
  logic [3:0] cnt;
  logic [6:0] golden, mismatch;
  logic [3:0] fail_nx;
  logic       last_cnt;
  always_comb begin
    golden   = vec == 2'd0 ? 7'h5C : vec == 2'd1 ? 7'h2E : vec == 2'd2 ? 7'h2A : 7'h43;
    mismatch = gate_res ^ golden;
    fail_nx  = fail_mask;
    fail_nx[vec] = |mismatch;
    last_cnt = cnt == 4'(SETTLE_CYCLES - 1);
    state_nx = state == IDLE   ? (start ? SETTLE : IDLE) :
               state == SETTLE ? (last_cnt ? SAMPLE : SETTLE) :
               state == SAMPLE ? (vec == 2'd3 ? DONE : SETTLE) : IDLE;
    busy = state == SETTLE || state == SAMPLE;
    done = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      vec       <= '0;
      cnt       <= '0;
      gate_a    <= 1'b0;
      gate_b    <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= '0;
      err_bits  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
          vec       <= '0;
          cnt       <= '0;
          gate_a    <= 1'b0;
          gate_b    <= 1'b0;
          pass      <= 1'b0;
          fail_mask <= '0;
          err_bits  <= '0;
        end
        SETTLE: cnt <= cnt + 4'd1;
        SAMPLE: begin
          err_bits  <= err_bits | mismatch;
          fail_mask <= fail_nx;
          cnt       <= '0;
          // pass lands with the final vector so it is already valid while done is high
          if (vec == 2'd3) begin
            gate_a <= 1'b0;
            gate_b <= 1'b0;
            pass   <= fail_nx == 4'd0;
          end else begin
            vec              <= vec + 2'd1;
            {gate_a, gate_b} <= vec + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
